rr_priority_encoder: RTL and testbench

- Parametrised, registered successor to the combinational one-hot/binary encoder.
- Takes a multi-hot request vector per streaming transfer and returns the binary index of one selected set bit, plus zero and multi-hot flags.
- Selection is fixed-priority (LSB first) or round-robin, starting after the last selected index.
- Sits between request-gathering logic (e.g. per-port FIFO non-empty flags) and mux/crossbar select logic; valid/ready on both sides.

---
 rtl/rr_priority_encoder.sv | 85 ++++++++
 tb/tb_rr_priority_encoder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_encoder.sv
// Registered multi-hot to binary index encoder with zero/multi-hot flags.
// Selection is fixed LSB-first or round-robin from the bit after the last grant.
module rr_priority_encoder #(
    parameter int unsigned  WIDTH       = 16,
    parameter int unsigned  ROUND_ROBIN = 0,
    localparam int unsigned IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [WIDTH-1:0]  in_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [IDX_W-1:0]  out_tdata,
    output logic              out_tzero,
    output logic              out_tmulti,
    output logic              out_tvalid,
    input  logic              out_tready
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] ptr_next;
    logic [WIDTH-1:0] rr_mask;
    logic [WIDTH-1:0] masked;
    logic             req_zero;
    logic             req_multi;
    logic             accept;

    function automatic logic [IDX_W-1:0] lsb_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Masked search covers ptr..WIDTH-1; the unmasked fallback covers the wrap to 0..ptr-1.
    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rr_mask[i] = (IDX_W'(i) >= ptr);
        end
        masked    = in_tdata & rr_mask;
        req_zero  = (in_tdata == '0);
        req_multi = ((in_tdata & (in_tdata - WIDTH'(1))) != '0);
        if ((ROUND_ROBIN != 0) && (masked != '0)) begin
            sel = lsb_idx(masked);
        end else begin
            sel = lsb_idx(in_tdata);
        end
        ptr_next = (sel == IDX_W'(WIDTH - 1)) ? '0 : sel + IDX_W'(1);
    end

    assign in_tready = ~clear & (~out_tvalid | out_tready);
    assign accept    = in_tvalid & in_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tzero  <= 1'b0;
            out_tmulti <= 1'b0;
        end else if (clear) begin
            ptr        <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tzero  <= 1'b0;
            out_tmulti <= 1'b0;
        end else if (accept) begin
            out_tvalid <= 1'b1;
            out_tdata  <= req_zero ? '0 : sel;
            out_tzero  <= req_zero;
            out_tmulti <= req_multi;
            if ((ROUND_ROBIN != 0) && !req_zero) begin
                ptr <= ptr_next;
            end
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Bench for rr_priority_encoder: fixed-priority W=8, round-robin W=8 and round-robin W=5
// instances, checked against a queue of results from an independent search model.
module tb_rr_priority_encoder;

    typedef struct packed {
        logic [2:0] idx;
        logic       zero;
        logic       multi;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int pb = 0;
    int pc = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic [7:0] a_in;  logic a_iv, a_ir;  logic [2:0] a_od;  logic a_oz, a_om, a_ov, a_or;
    logic [7:0] b_in;  logic b_iv, b_ir;  logic [2:0] b_od;  logic b_oz, b_om, b_ov, b_or;
    logic [4:0] c_in;  logic c_iv, c_ir;  logic [2:0] c_od;  logic c_oz, c_om, c_ov, c_or;

    rr_priority_encoder #(.WIDTH(8), .ROUND_ROBIN(0)) u_fixed8 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_tdata(a_in), .in_tvalid(a_iv), .in_tready(a_ir),
        .out_tdata(a_od), .out_tzero(a_oz), .out_tmulti(a_om),
        .out_tvalid(a_ov), .out_tready(a_or)
    );

    rr_priority_encoder #(.WIDTH(8), .ROUND_ROBIN(1)) u_rr8 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_tdata(b_in), .in_tvalid(b_iv), .in_tready(b_ir),
        .out_tdata(b_od), .out_tzero(b_oz), .out_tmulti(b_om),
        .out_tvalid(b_ov), .out_tready(b_or)
    );

    rr_priority_encoder #(.WIDTH(5), .ROUND_ROBIN(1)) u_rr5 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_tdata(c_in), .in_tvalid(c_iv), .in_tready(c_ir),
        .out_tdata(c_od), .out_tzero(c_oz), .out_tmulti(c_om),
        .out_tvalid(c_ov), .out_tready(c_or)
    );

    // Walk bits in search order and count set bits explicitly.
    function automatic exp_t model(input logic [7:0] v, input int w, input bit rr, input int ptr);
        exp_t e;
        int   cnt;
        int   j;
        e      = '0;
        e.zero = 1'b1;
        cnt    = 0;
        for (int k = 0; k < w; k++) begin
            j = rr ? (ptr + k) % w : k;
            if (v[j]) begin
                cnt++;
                if (e.zero) begin
                    e.idx  = 3'(j);
                    e.zero = 1'b0;
                end
            end
        end
        e.multi = (cnt >= 2);
        return e;
    endfunction

    function automatic int next_ptr(input exp_t e, input int w, input int ptr);
        return e.zero ? ptr : (int'(e.idx) + 1) % w;
    endfunction

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0;
        a_iv = 1'b0; a_in = '0; a_or = 1'b1;
        b_iv = 1'b0; b_in = '0; b_or = 1'b1;
        c_iv = 1'b0; c_in = '0; c_or = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_ov, a_od, a_oz, a_om} !== 6'b0) begin
            n_err++; $display("FAIL reset_fixed8 out=%b expected 000000", {a_ov, a_od, a_oz, a_om});
        end
        n_cmp++;
        if ({b_ov, b_od, b_oz, b_om} !== 6'b0) begin
            n_err++; $display("FAIL reset_rr8 out=%b expected 000000", {b_ov, b_od, b_oz, b_om});
        end
        n_cmp++;
        if ({c_ov, c_od, c_oz, c_om} !== 6'b0) begin
            n_err++; $display("FAIL reset_rr5 out=%b expected 000000", {c_ov, c_od, c_oz, c_om});
        end
        n_cmp++;
        if (b_ir !== 1'b1) begin
            n_err++; $display("FAIL reset_ready in_tready=%b expected 1", b_ir);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        logic [7:0] stim [4];
        exp_t e;
        int   i;
        int   cyc;
        stim = '{8'hA4, 8'h80, 8'h00, 8'h06};
        i = 0; cyc = 0; a_or = 1'b1;
        while ((i < 4 || qa.size() != 0) && cyc < 40) begin
            a_iv = (i < 4);
            a_in = (i < 4) ? stim[i] : 8'h00;
            @(negedge clk);
            if (a_ov && a_or) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++; $display("FAIL fixed spurious output idx=%0d", a_od);
                end else begin
                    e = qa.pop_front();
                    if ({a_od, a_oz, a_om} !== e) begin
                        n_err++;
                        $display("FAIL fixed idx/zero/multi got %0d/%b/%b expected %0d/%b/%b",
                                 a_od, a_oz, a_om, e.idx, e.zero, e.multi);
                    end
                end
            end
            if (a_iv && a_ir) begin
                qa.push_back(model(a_in, 8, 1'b0, 0));
                i++;
            end
            @(posedge clk); #1; cyc++;
        end
        a_iv = 1'b0;
        n_cmp++;
        if (cyc >= 40) begin
            n_err++; $display("FAIL fixed timeout sent=%0d pending=%0d expected all drained", i, qa.size());
        end
    endtask

    task automatic test_rr_sweep();
        exp_t e;
        int   i;
        int   cyc;
        i = 0; cyc = 0; b_or = 1'b1;
        while ((i < 10 || qb.size() != 0) && cyc < 40) begin
            b_iv = (i < 10);
            b_in = 8'hFF;
            @(negedge clk);
            if (b_ov && b_or) begin
                n_cmp++;
                if (qb.size() == 0) begin
                    n_err++; $display("FAIL rr_sweep spurious output idx=%0d", b_od);
                end else begin
                    e = qb.pop_front();
                    if ({b_od, b_oz, b_om} !== e) begin
                        n_err++;
                        $display("FAIL rr_sweep idx/zero/multi got %0d/%b/%b expected %0d/%b/%b",
                                 b_od, b_oz, b_om, e.idx, e.zero, e.multi);
                    end
                end
            end
            if (b_iv && b_ir) begin
                e = model(b_in, 8, 1'b1, pb);
                pb = next_ptr(e, 8, pb);
                qb.push_back(e);
                i++;
            end
            @(posedge clk); #1; cyc++;
        end
        b_iv = 1'b0;
        // Ten beats at one per cycle plus one cycle of latency.
        n_cmp++;
        if (cyc != 11) begin
            n_err++; $display("FAIL rr_sweep throughput cycles=%0d expected 11", cyc);
        end
    endtask

    task automatic test_rr_81_zero();
        logic [7:0] stim [7];
        bit         vld  [7];
        exp_t e;
        int   i;
        int   cyc;
        stim = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h00, 8'h80, 8'h81};
        vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; pb = 0; pc = 0;
        i = 0; cyc = 0; b_or = 1'b1;
        while ((i < 7 || qb.size() != 0) && cyc < 40) begin
            b_iv = (i < 7) ? vld[i] : 1'b0;
            b_in = (i < 7) ? stim[i] : 8'h00;
            @(negedge clk);
            if (b_ov && b_or) begin
                n_cmp++;
                if (qb.size() == 0) begin
                    n_err++; $display("FAIL rr_81 spurious output idx=%0d", b_od);
                end else begin
                    e = qb.pop_front();
                    if ({b_od, b_oz, b_om} !== e) begin
                        n_err++;
                        $display("FAIL rr_81 idx/zero/multi got %0d/%b/%b expected %0d/%b/%b",
                                 b_od, b_oz, b_om, e.idx, e.zero, e.multi);
                    end
                end
            end
            if (b_iv && b_ir) begin
                e = model(b_in, 8, 1'b1, pb);
                pb = next_ptr(e, 8, pb);
                qb.push_back(e);
            end
            if (i < 7 && (!b_iv || b_ir)) i++;
            @(posedge clk); #1; cyc++;
        end
        b_iv = 1'b0;
        n_cmp++;
        if (cyc >= 40) begin
            n_err++; $display("FAIL rr_81 timeout pending=%0d expected 0", qb.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        b_or = 1'b0; b_iv = 1'b1; b_in = 8'h0C;
        @(negedge clk);
        e = model(8'h0C, 8, 1'b1, pb);
        pb = next_ptr(e, 8, pb);
        qb.push_back(e);
        @(posedge clk); #1;
        b_in = 8'h30;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({b_ov, b_ir, b_od, b_oz, b_om} !== {2'b10, qb[0]}) begin
                n_err++;
                $display("FAIL stall%0d valid/ready/idx/zero/multi got %b/%b/%0d/%b/%b expected 1/0/%0d/%b/%b",
                         k, b_ov, b_ir, b_od, b_oz, b_om, qb[0].idx, qb[0].zero, qb[0].multi);
            end
            @(posedge clk); #1;
        end
        b_or = 1'b1;
        @(negedge clk);
        e = qb.pop_front();
        n_cmp++;
        if ({b_ov, b_ir, b_od, b_oz, b_om} !== {2'b11, e}) begin
            n_err++;
            $display("FAIL release valid/ready/idx got %b/%b/%0d expected 1/1/%0d", b_ov, b_ir, b_od, e.idx);
        end
        e = model(8'h30, 8, 1'b1, pb);
        pb = next_ptr(e, 8, pb);
        qb.push_back(e);
        @(posedge clk); #1;
        b_iv = 1'b0;
        @(negedge clk);
        e = qb.pop_front();
        n_cmp++;
        if ({b_ov, b_od, b_oz, b_om} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL after_release valid/idx/zero/multi got %b/%0d/%b/%b expected 1/%0d/%b/%b",
                     b_ov, b_od, b_oz, b_om, e.idx, e.zero, e.multi);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap5();
        logic [4:0] stim [5];
        exp_t e;
        int   i;
        int   cyc;
        stim = '{5'b10000, 5'b00001, 5'b11111, 5'b10001, 5'b00011};
        i = 0; cyc = 0; c_or = 1'b1;
        while ((i < 5 || qc.size() != 0) && cyc < 40) begin
            c_iv = (i < 5);
            c_in = (i < 5) ? stim[i] : 5'b0;
            @(negedge clk);
            if (c_ov && c_or) begin
                n_cmp++;
                if (qc.size() == 0) begin
                    n_err++; $display("FAIL wrap5 spurious output idx=%0d", c_od);
                end else begin
                    e = qc.pop_front();
                    if ({c_od, c_oz, c_om} !== e) begin
                        n_err++;
                        $display("FAIL wrap5 idx/zero/multi got %0d/%b/%b expected %0d/%b/%b",
                                 c_od, c_oz, c_om, e.idx, e.zero, e.multi);
                    end
                end
            end
            if (c_iv && c_ir) begin
                e = model({3'b000, c_in}, 5, 1'b1, pc);
                pc = next_ptr(e, 5, pc);
                qc.push_back(e);
                i++;
            end
            @(posedge clk); #1; cyc++;
        end
        c_iv = 1'b0;
        n_cmp++;
        if (cyc >= 40) begin
            n_err++; $display("FAIL wrap5 timeout pending=%0d expected 0", qc.size());
        end
    endtask

    task automatic test_clear();
        // Leave a result pending and move ptr away from 0 before clearing.
        b_or = 1'b0; b_iv = 1'b1; b_in = 8'h40;
        @(posedge clk); #1;
        clear = 1'b1; b_in = 8'h55;
        @(negedge clk);
        n_cmp++;
        if ({b_ov, b_ir} !== 2'b10) begin
            n_err++; $display("FAIL clear_cycle valid/ready got %b/%b expected 1/0", b_ov, b_ir);
        end
        @(posedge clk); #1;
        clear = 1'b0; b_iv = 1'b0;
        qa.delete(); qb.delete(); qc.delete(); pb = 0; pc = 0;
        @(negedge clk);
        n_cmp++;
        if (b_ov !== 1'b0) begin
            n_err++; $display("FAIL clear_discard out_tvalid=%b expected 0", b_ov);
        end
        @(posedge clk); #1;
        b_or = 1'b1; b_iv = 1'b1; b_in = 8'hFF;
        @(posedge clk); #1;
        b_iv = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({b_ov, b_od, b_oz, b_om} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL clear_ptr valid/idx/zero/multi got %b/%0d/%b/%b expected 1/0/0/1", b_ov, b_od, b_oz, b_om);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        b_or = 1'b0; b_iv = 1'b1; b_in = 8'h18;
        @(posedge clk); #1;
        b_iv = 1'b0;
        n_cmp++;
        if (b_ov !== 1'b1) begin
            n_err++; $display("FAIL pre_reset out_tvalid=%b expected 1", b_ov);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({b_ov, b_od, b_oz, b_om} !== 6'b0) begin
            n_err++; $display("FAIL reset_mid out=%b expected 000000", {b_ov, b_od, b_oz, b_om});
        end
        @(negedge clk);
        reset = 1'b0;
        qa.delete(); qb.delete(); qc.delete(); pb = 0; pc = 0;
        b_or = 1'b1;
        @(posedge clk); #1;
        b_iv = 1'b1; b_in = 8'hFF;
        @(posedge clk); #1;
        b_iv = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({b_ov, b_od, b_oz, b_om} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_ptr valid/idx/zero/multi got %b/%0d/%b/%b expected 1/0/0/1", b_ov, b_od, b_oz, b_om);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_sweep();
        test_rr_81_zero();
        test_backpressure();
        test_wrap5();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
